// File: rtl/pusch_seq_pkg.sv
// Shared types and constants for the PUSCH transmit-chain sequencer.
package pusch_seq_pkg;

  // Sequencer controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_t;

  // Stage order through the chain
  localparam logic [2:0] STG_CRC  = 3'd0;
  localparam logic [2:0] STG_HARQ = 3'd1;
  localparam logic [2:0] STG_SCR  = 3'd2;
  localparam logic [2:0] STG_MOD  = 3'd3;
  localparam logic [2:0] STG_REM  = 3'd4;
  localparam logic [2:0] STG_IFFT = 3'd5;

  // Reported error causes
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CFG     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_UNEXP   = 2'd3
  } err_code_t;

  // Legal LDPC base graphs and modulation orders
  localparam logic [1:0] BG_1     = 2'd1;
  localparam logic [1:0] BG_2     = 2'd2;
  localparam logic [2:0] QM_BPSK  = 3'd1;
  localparam logic [2:0] QM_QPSK  = 3'd2;
  localparam logic [2:0] QM_16QAM = 3'd4;
  localparam logic [2:0] QM_64QAM = 3'd6;

  // True when a transport-block configuration can be processed
  function automatic logic cfg_valid(input logic [1:0]  bg,
                                     input logic [2:0]  qm,
                                     input logic [3:0]  sym_start,
                                     input logic [3:0]  sym_end,
                                     input logic [16:0] coded_bits);
    logic bg_ok;
    logic qm_ok;
    bg_ok = (bg == BG_1) || (bg == BG_2);
    qm_ok = (qm == QM_BPSK) || (qm == QM_QPSK) || (qm == QM_16QAM) || (qm == QM_64QAM);
    return bg_ok && qm_ok && (sym_start <= sym_end) && (coded_bits != 17'd0);
  endfunction

endpackage

// File: rtl/pusch_seq_watchdog.sv
// Per-stage watchdog: loadable down-counter; a zero load disables it.
module pusch_seq_watchdog import pusch_seq_pkg::*; #(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [TO_W-1:0] limit,
  input  logic            dec,
  output logic            expire
);

  logic [TO_W-1:0] count_reg;

  // Load at stage launch, count down while the stage is outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= limit;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // A counter parked at zero never reaches one, so it stays silent
  assign expire = (count_reg == TO_W'(1));

endmodule

// File: rtl/pusch_chain_sequencer.sv
// PUSCH transmit-chain sequencer: validates config, launches each stage in
// turn, waits for its done under a watchdog and reports the chain result.
module pusch_chain_sequencer import pusch_seq_pkg::*; #(
  parameter int N_STG = 6,
  parameter int TO_W  = 20,
  parameter int CYC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             err_clr,
  input  logic [TO_W-1:0]  timeout_limit,
  input  logic [1:0]       base_graph,
  input  logic [1:0]       rv_number,
  input  logic [3:0]       process_number,
  input  logic [16:0]      available_coded_bits,
  input  logic [2:0]       modulation_order,
  input  logic [3:0]       Sym_Start_REM,
  input  logic [3:0]       Sym_End_REM,
  output logic [1:0]       cfg_base_graph,
  output logic [1:0]       cfg_rv_number,
  output logic [3:0]       cfg_process_number,
  output logic [16:0]      cfg_available_coded_bits,
  output logic [2:0]       cfg_modulation_order,
  output logic [3:0]       cfg_Sym_Start_REM,
  output logic [3:0]       cfg_Sym_End_REM,
  output logic [N_STG-1:0] stage_start,
  input  logic [N_STG-1:0] stage_done,
  output logic             busy,
  output logic             chain_done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [2:0]       err_stage,
  output logic [CYC_W-1:0] cycle_count
);

  seq_state_t       state_reg, state_next;
  logic [2:0]       index_reg, index_next;
  err_code_t        err_code_reg, err_code_next;
  logic [2:0]       err_stage_reg, err_stage_next;
  logic [CYC_W-1:0] cycle_count_reg;
  logic [N_STG-1:0] idx_onehot;
  logic             cfg_load, cnt_clr, wd_load, wd_dec, wd_expire;
  logic             done_hit, done_foreign;

  // One-hot decode of the current stage index
  for (genvar gi = 0; gi < N_STG; gi++) begin : g_onehot
    assign idx_onehot[gi] = (index_reg == 3'(gi));
  end

  assign done_hit     = |(stage_done & idx_onehot);
  assign done_foreign = |(stage_done & ~idx_onehot);

  pusch_seq_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .limit  (timeout_limit),
    .dec    (wd_dec),
    .expire (wd_expire)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and control decode; abort overrides everything
  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    err_code_next  = err_code_reg;
    err_stage_next = err_stage_reg;
    cfg_load       = 1'b0;
    cnt_clr        = 1'b0;
    wd_load        = 1'b0;
    wd_dec         = 1'b0;
    if (abort) begin
      state_next     = ST_IDLE;
      err_code_next  = ERR_NONE;
      err_stage_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (cfg_valid(base_graph, modulation_order, Sym_Start_REM, Sym_End_REM,
                          available_coded_bits)) begin
              cfg_load   = 1'b1;
              cnt_clr    = 1'b1;
              index_next = STG_CRC;
              state_next = ST_LAUNCH;
            end else begin
              state_next     = ST_ERROR;
              err_code_next  = ERR_CFG;
              err_stage_next = '0;
            end
          end
        end
        ST_LAUNCH: begin
          wd_load    = 1'b1;
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          // Foreign done bits beat a correct done; a correct done beats expiry
          if (done_foreign) begin
            state_next     = ST_ERROR;
            err_code_next  = ERR_UNEXP;
            err_stage_next = index_reg;
          end else if (done_hit) begin
            if (index_reg == STG_IFFT) begin
              state_next = ST_DONE;
            end else begin
              index_next = index_reg + 3'd1;
              state_next = ST_LAUNCH;
            end
          end else if (wd_expire) begin
            state_next     = ST_ERROR;
            err_code_next  = ERR_TIMEOUT;
            err_stage_next = index_reg;
          end else begin
            wd_dec = 1'b1;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        ST_ERROR: begin
          if (err_clr) begin
            state_next     = ST_IDLE;
            err_code_next  = ERR_NONE;
            err_stage_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Stage index, error report and saturating busy-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_reg       <= '0;
      err_code_reg    <= ERR_NONE;
      err_stage_reg   <= '0;
      cycle_count_reg <= '0;
    end else begin
      index_reg     <= index_next;
      err_code_reg  <= err_code_next;
      err_stage_reg <= err_stage_next;
      if (cnt_clr)
        cycle_count_reg <= '0;
      else if (busy && (cycle_count_reg != '1))
        cycle_count_reg <= cycle_count_reg + 1'b1;
    end
  end

  // Configuration latched only on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_base_graph           <= '0;
      cfg_rv_number            <= '0;
      cfg_process_number       <= '0;
      cfg_available_coded_bits <= '0;
      cfg_modulation_order     <= '0;
      cfg_Sym_Start_REM        <= '0;
      cfg_Sym_End_REM          <= '0;
    end else if (cfg_load) begin
      cfg_base_graph           <= base_graph;
      cfg_rv_number            <= rv_number;
      cfg_process_number       <= process_number;
      cfg_available_coded_bits <= available_coded_bits;
      cfg_modulation_order     <= modulation_order;
      cfg_Sym_Start_REM        <= Sym_Start_REM;
      cfg_Sym_End_REM          <= Sym_End_REM;
    end
  end

  assign busy        = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT);
  assign stage_start = (state_reg == ST_LAUNCH) ? idx_onehot : '0;
  assign chain_done  = (state_reg == ST_DONE);
  assign error       = (state_reg == ST_ERROR);
  assign err_code    = err_code_reg;
  assign err_stage   = err_stage_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_pusch_chain_sequencer.sv
// Directed self-checking bench for the PUSCH chain sequencer.
module tb_pusch_chain_sequencer;

  logic        clk;
  logic        reset;
  logic        start, abort, err_clr;
  logic [19:0] timeout_limit;
  logic [1:0]  base_graph, rv_number;
  logic [3:0]  process_number;
  logic [16:0] available_coded_bits;
  logic [2:0]  modulation_order;
  logic [3:0]  Sym_Start_REM, Sym_End_REM;
  logic [1:0]  cfg_base_graph, cfg_rv_number;
  logic [3:0]  cfg_process_number;
  logic [16:0] cfg_available_coded_bits;
  logic [2:0]  cfg_modulation_order;
  logic [3:0]  cfg_Sym_Start_REM, cfg_Sym_End_REM;
  logic [5:0]  stage_start, stage_done;
  logic        busy, chain_done, error;
  logic [1:0]  err_code;
  logic [2:0]  err_stage;
  logic [23:0] cycle_count;

  int n_cmp;
  int n_fail;
  int cyc;

  pusch_chain_sequencer dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .abort                    (abort),
    .err_clr                  (err_clr),
    .timeout_limit            (timeout_limit),
    .base_graph               (base_graph),
    .rv_number                (rv_number),
    .process_number           (process_number),
    .available_coded_bits     (available_coded_bits),
    .modulation_order         (modulation_order),
    .Sym_Start_REM            (Sym_Start_REM),
    .Sym_End_REM              (Sym_End_REM),
    .cfg_base_graph           (cfg_base_graph),
    .cfg_rv_number            (cfg_rv_number),
    .cfg_process_number       (cfg_process_number),
    .cfg_available_coded_bits (cfg_available_coded_bits),
    .cfg_modulation_order     (cfg_modulation_order),
    .cfg_Sym_Start_REM        (cfg_Sym_Start_REM),
    .cfg_Sym_End_REM          (cfg_Sym_End_REM),
    .stage_start              (stage_start),
    .stage_done               (stage_done),
    .busy                     (busy),
    .chain_done               (chain_done),
    .error                    (error),
    .err_code                 (err_code),
    .err_stage                (err_stage),
    .cycle_count              (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are looked at 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_cfg(input logic [1:0] bg, input logic [1:0] rv, input logic [3:0] prc,
                         input logic [16:0] g, input logic [2:0] qm, input logic [3:0] ss,
                         input logic [3:0] se, input logic [19:0] lim);
    base_graph = bg; rv_number = rv; process_number = prc; available_coded_bits = g;
    modulation_order = qm; Sym_Start_REM = ss; Sym_End_REM = se; timeout_limit = lim;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Called in a LAUNCH cycle: checks the pulse, then returns done in WAIT cycle dly
  task automatic run_stage(input int s, input int dly);
    chk($sformatf("start_s%0d", s), 32'(stage_start), 32'(1 << s));
    repeat (dly) tick();
    stage_done = 6'(1 << s);
    tick();
    stage_done = '0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; err_clr = 1'b0; stage_done = '0;
    set_cfg(2'd0, 2'd0, 4'd0, 17'd0, 3'd0, 4'd0, 4'd0, 20'd0);
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_stage_start", 32'(stage_start), 0);
    chk("rst_cycle_count", 32'(cycle_count), 0);
    chk("rst_cfg_bg", 32'(cfg_base_graph), 0);
    reset = 1'b1;
    tick();

    // Nominal run, each stage done 5 cycles after its start
    set_cfg(2'd2, 2'd0, 4'd1, 17'd4802, 3'd2, 4'd1, 4'd3, 20'd1000);
    cyc = 0;
    do_start();
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("nom_launch_cyc_s%0d", s), 32'(cyc), 32'(1 + 6 * s));
      run_stage(s, 5);
    end
    chk("nom_done_cyc", 32'(cyc), 37);
    chk("nom_chain_done", 32'(chain_done), 1);
    chk("nom_cycle_count", 32'(cycle_count), 36);
    chk("nom_cfg_bg", 32'(cfg_base_graph), 2);
    chk("nom_cfg_rv", 32'(cfg_rv_number), 0);
    chk("nom_cfg_proc", 32'(cfg_process_number), 1);
    chk("nom_cfg_g", 32'(cfg_available_coded_bits), 4802);
    chk("nom_cfg_qm", 32'(cfg_modulation_order), 2);
    chk("nom_cfg_ss", 32'(cfg_Sym_Start_REM), 1);
    chk("nom_cfg_se", 32'(cfg_Sym_End_REM), 3);
    tick();
    chk("nom_done_pulse_end", 32'(chain_done), 0);
    chk("nom_idle_busy", 32'(busy), 0);

    // Bad config: Qm=3
    set_cfg(2'd1, 2'd1, 4'd2, 17'd100, 3'd3, 4'd1, 4'd3, 20'd1000);
    do_start();
    chk("badqm_error", 32'(error), 1);
    chk("badqm_code", 32'(err_code), 1);
    chk("badqm_stage", 32'(err_stage), 0);
    chk("badqm_no_start", 32'(stage_start), 0);
    chk("badqm_cfg_kept", 32'(cfg_modulation_order), 2);
    tick();
    chk("badqm_held", 32'(err_code), 1);
    clr_err();
    chk("badqm_clr_error", 32'(error), 0);
    chk("badqm_clr_code", 32'(err_code), 0);

    // Bad config: symbol range reversed
    set_cfg(2'd1, 2'd0, 4'd0, 17'd100, 3'd4, 4'd4, 4'd3, 20'd1000);
    do_start();
    chk("badsym_code", 32'(err_code), 1);
    clr_err();

    // Timeout: limit 8, scrambler never answers
    set_cfg(2'd1, 2'd0, 4'd0, 17'd100, 3'd4, 4'd0, 4'd13, 20'd8);
    do_start();
    run_stage(0, 2);
    run_stage(1, 2);
    chk("to_launch_scr", 32'(stage_start), 6'b000100);
    repeat (8) tick();
    chk("to_wait8_error", 32'(error), 0);
    chk("to_wait8_busy", 32'(busy), 1);
    tick();
    chk("to_error", 32'(error), 1);
    chk("to_code", 32'(err_code), 2);
    chk("to_stage", 32'(err_stage), 2);
    clr_err();

    // Watchdog disabled with limit 0
    timeout_limit = 20'd0;
    do_start();
    chk("wd0_launch", 32'(stage_start), 6'b000001);
    repeat (60) tick();
    chk("wd0_still_busy", 32'(busy), 1);
    chk("wd0_no_error", 32'(error), 0);
    stage_done = 6'b000001;
    tick();
    stage_done = '0;
    chk("wd0_next_launch", 32'(stage_start), 6'b000010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wd0_abort_busy", 32'(busy), 0);

    // Boundary: done on exactly the 8th WAIT cycle is accepted
    timeout_limit = 20'd8;
    do_start();
    run_stage(0, 1);
    run_stage(1, 8);
    chk("bnd_accept_launch", 32'(stage_start), 6'b000100);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Boundary: 9th WAIT cycle is too late
    do_start();
    run_stage(0, 1);
    repeat (8) tick();
    chk("bnd_late_wait8", 32'(error), 0);
    tick();
    chk("bnd_late_error", 32'(error), 1);
    chk("bnd_late_code", 32'(err_code), 2);
    chk("bnd_late_stage", 32'(err_stage), 1);
    stage_done = 6'b000010;
    tick();
    stage_done = '0;
    chk("bnd_late_held", 32'(err_code), 2);
    clr_err();

    // Unexpected done from stage 4 while waiting on stage 3
    timeout_limit = 20'd1000;
    do_start();
    run_stage(0, 2);
    run_stage(1, 2);
    run_stage(2, 2);
    chk("unx_launch_mod", 32'(stage_start), 6'b001000);
    repeat (2) tick();
    stage_done = 6'b010000;
    tick();
    stage_done = '0;
    chk("unx_error", 32'(error), 1);
    chk("unx_code", 32'(err_code), 3);
    chk("unx_stage", 32'(err_stage), 3);
    clr_err();

    // Correct and foreign done together
    do_start();
    tick();
    stage_done = 6'b000011;
    tick();
    stage_done = '0;
    chk("both_code", 32'(err_code), 3);
    chk("both_stage", 32'(err_stage), 0);
    clr_err();

    // Abort mid stage 4, beating a simultaneous start and done
    do_start();
    run_stage(0, 2);
    run_stage(1, 2);
    run_stage(2, 2);
    run_stage(3, 2);
    chk("abt_launch_rem", 32'(stage_start), 6'b010000);
    repeat (2) tick();
    abort = 1'b1; start = 1'b1; stage_done = 6'b010000;
    tick();
    abort = 1'b0; start = 1'b0; stage_done = '0;
    chk("abt_busy", 32'(busy), 0);
    chk("abt_chain_done", 32'(chain_done), 0);
    chk("abt_stage_start", 32'(stage_start), 0);
    chk("abt_error", 32'(error), 0);
    tick();
    chk("abt_stay_idle", 32'(busy), 0);

    // Clean rerun at minimum stage latency
    cyc = 0;
    do_start();
    for (int s = 0; s < 6; s++) run_stage(s, 1);
    chk("rerun_done_cyc", 32'(cyc), 13);
    chk("rerun_chain_done", 32'(chain_done), 1);
    chk("rerun_cycle_count", 32'(cycle_count), 12);
    tick();

    // Async reset in the middle of a WAIT
    do_start();
    run_stage(0, 2);
    repeat (3) tick();
    chk("ar_pre_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_stage_start", 32'(stage_start), 0);
    chk("ar_cycle_count", 32'(cycle_count), 0);
    chk("ar_cfg_bg", 32'(cfg_base_graph), 0);
    chk("ar_err_code", 32'(err_code), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_after_busy", 32'(busy), 0);
    chk("ar_after_done", 32'(chain_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
